parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Entry/exit barrier controller that drives the event side of the parking counter interface. It turns loop-detector, card-reader and pass-beam sensors into one-cycle car_entered/car_exited pulses with a university/regular tag. It gates entry on the counter's space flags and watches the counter's illegal_enter/illegal_exit responses. It sits between the gate hardware and the parking occupancy counter; both share clk and reset.

Parameters:
OPEN_TIMEOUT, 64, cycles the barrier stays open waiting for pass_sensor to rise before aborting (>=1)
CLOSE_CYCLES, 4, cycles spent in CLOSE before returning to IDLE (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
in_loop  input  1  car present at entry barrier
in_card_valid  input  1  entry card read strobe, sampled in IDLE
in_card_uni  input  1  entry card type, 1=university; valid with in_card_valid
in_pass  input  1  entry pass beam, high while car is under barrier
out_loop, out_card_valid, out_card_uni, out_pass  input  1 each  same meanings for exit gate
uni_is_vacated_space  input  1  counter: university space available
is_vacated_space  input  1  counter: regular space available
illegal_enter  input  1  counter: last entry rejected (valid cycle after pulse)
illegal_exit  input  1  counter: last exit rejected (valid cycle after pulse)
car_entered  output  1  one-cycle entry event
is_uni_car_entered  output  1  tag, valid with car_entered, else 0
car_exited  output  1  one-cycle exit event
is_uni_car_exited  output  1  tag, valid with car_exited, else 0
barrier_in_open, barrier_out_open  output  1 each  barrier drive
reject_in  output  1  entry refused indicator
timeout_in, timeout_out  output  1 each  one-cycle abort pulse
fault  output  1  sticky: counter flagged an event illegal

Behaviour:
- All inputs synchronous to clk; all outputs registered. Reset: every output 0, both FSMs IDLE, timers 0, latched card type 0.
- Each gate runs an identical FSM: IDLE, DECIDE, OPEN, PASSING, CLOSE, REJECT.
- IDLE: loop && card_valid -> latch card_uni, go to DECIDE. card_valid without loop is ignored.
- DECIDE (1 cycle): entry gate allows if (uni && (uni_is_vacated_space || is_vacated_space)) || (!uni && is_vacated_space). Uni overflow into regular space is intended. Exit gate always allows.
  - allow -> OPEN, timer=0.
  - deny -> REJECT.
- OPEN: barrier=1; timer increments each cycle.
  - pass=1 -> PASSING.
  - Else timer==OPEN_TIMEOUT-1 -> CLOSE with a one-cycle timeout pulse and no car event.
  - A pass rise in the same cycle as expiry wins: go to PASSING.
- PASSING: barrier=1; wait for pass=0. On that cycle emit the event pulse (car_entered/car_exited) with the latched tag, then go to CLOSE. No timeout applies in PASSING.
- CLOSE: barrier=0; count CLOSE_CYCLES, then IDLE. Sensor inputs are ignored.
- REJECT: reject_in=1 while in state; return to IDLE the cycle after loop=0. Only the exit FSM never reaches REJECT.
- Exactly one event per admitted car. Entry and exit pulses may coincide in the same cycle; the counter resolves that case.
- fault: set if illegal_enter is high in the cycle after car_entered, or illegal_exit is high in the cycle after car_exited. Cleared only by reset. illegal_* at other times is ignored.
- Space flags are sampled only in DECIDE; later changes do not affect a car already admitted.
- Reset mid-operation: barrier closes immediately, any pending event is dropped, fault is cleared.
- Timer width is $clog2(OPEN_TIMEOUT+1) and is saturation-free by construction.

Decomposition:
- Shared package parking_pkg: gate state enum (IDLE, DECIDE, OPEN, PASSING, CLOSE, REJECT) and space-check function allow_entry(uni, uni_space, reg_space).
- Sub-module parking_gate_fsm, parameterised by CHECK_SPACE (1 for entry, 0 for exit) plus the timeouts. It is instantiated twice; the top adds fault tracking and output wiring.

Test Plan:
1. Regular entry, is_vacated_space=1: loop + card (uni=0), pass high 3 cycles, then low -> barrier_in_open rises 2 cycles after card, car_entered=1 with is_uni_car_entered=0 for exactly 1 cycle on the pass-fall cycle, barrier low for 4 cycles, then IDLE.
2. Uni overflow: uni_is_vacated_space=0, is_vacated_space=1, uni card -> admitted, event tagged is_uni_car_entered=1. Both flags 0 -> reject_in high until loop drops, no event.
3. Timeout: admitted, in_pass never rises -> timeout_in pulses at cycle 64 of OPEN, barrier closes, no car_entered.
4. Simultaneous: entry and exit pass beams fall in the same cycle -> car_entered and car_exited both pulse that cycle with correct tags.
5. Fault: drive illegal_exit=1 the cycle after car_exited -> fault=1 and stays 1. Apply illegal_enter while no pulse preceded it -> fault unaffected.
6. Reset mid-PASSING: reset asserted -> next cycle all outputs 0; pass falling afterwards produces no event.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking barrier controllers.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    OPEN,
    PASSING,
    CLOSE,
    REJECT
  } gate_state_t;

  // Entry admission rule: a university card may overflow into a regular space.
  function automatic logic allow_entry(input logic uni, input logic uni_space, input logic reg_space);
    return (uni && (uni_space || reg_space)) || (!uni && reg_space);
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Event/response link between the gate controller and the occupancy counter.
interface parking_gate_ctrl_if;

  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic illegal_enter;
  logic illegal_exit;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;

  modport master (
    input  uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );

  modport slave (
    output uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );

endinterface

// File: rtl/parking_gate_fsm.sv
// One barrier: card decision, open window with timeout, pass tracking and close hold-off.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter bit          CHECK_SPACE  = 1'b1,
  parameter int unsigned OPEN_TIMEOUT = 64,
  parameter int unsigned CLOSE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic loop,
  input  logic card_valid,
  input  logic card_uni,
  input  logic pass,
  input  logic uni_space,
  input  logic reg_space,
  output logic barrier,
  output logic car_event,
  output logic car_uni,
  output logic timeout,
  output logic reject
);

  localparam int unsigned TW = $clog2(OPEN_TIMEOUT + 1);
  localparam int unsigned CW = $clog2(CLOSE_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [CW-1:0] CLAST = CW'(CLOSE_CYCLES - 1);

  gate_state_t   state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [CW-1:0] close_cnt, close_cnt_d;
  logic          uni_q, uni_d;
  logic          barrier_d, car_event_d, car_uni_d, timeout_d, reject_d;

  // State register with its timers and latched card type.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      close_cnt <= '0;
      uni_q     <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      close_cnt <= close_cnt_d;
      uni_q     <= uni_d;
    end
  end

  // Next-state logic; space flags only matter in DECIDE.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    close_cnt_d = close_cnt;
    uni_d       = uni_q;
    case (state)
      IDLE: begin
        if (loop && card_valid) begin
          state_d = DECIDE;
          uni_d   = card_uni;
        end
      end
      DECIDE: begin
        if (!CHECK_SPACE || allow_entry(uni_q, uni_space, reg_space)) begin
          state_d = OPEN;
          timer_d = '0;
        end else begin
          state_d = REJECT;
        end
      end
      OPEN: begin
        if (pass) begin
          state_d = PASSING;
        end else if (timer == TLAST) begin
          state_d     = CLOSE;
          close_cnt_d = '0;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      PASSING: begin
        if (!pass) begin
          state_d     = CLOSE;
          close_cnt_d = '0;
        end
      end
      CLOSE: begin
        if (close_cnt == CLAST) state_d = IDLE;
        else                    close_cnt_d = close_cnt + CW'(1);
      end
      REJECT: begin
        if (!loop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state and the transitions that produce pulses.
  always_comb begin
    barrier_d   = (state_d == OPEN) || (state_d == PASSING);
    reject_d    = (state_d == REJECT);
    car_event_d = (state == PASSING) && !pass;
    car_uni_d   = car_event_d && uni_q;
    timeout_d   = (state == OPEN) && !pass && (timer == TLAST);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      barrier   <= 1'b0;
      car_event <= 1'b0;
      car_uni   <= 1'b0;
      timeout   <= 1'b0;
      reject    <= 1'b0;
    end else begin
      barrier   <= barrier_d;
      car_event <= car_event_d;
      car_uni   <= car_uni_d;
      timeout   <= timeout_d;
      reject    <= reject_d;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier pair feeding the occupancy counter, with illegal-event fault tracking.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = 64,
  parameter int unsigned CLOSE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_loop,
  input  logic                       in_card_valid,
  input  logic                       in_card_uni,
  input  logic                       in_pass,
  input  logic                       out_loop,
  input  logic                       out_card_valid,
  input  logic                       out_card_uni,
  input  logic                       out_pass,
  parking_gate_ctrl_if.master        counter,
  output logic                       barrier_in_open,
  output logic                       barrier_out_open,
  output logic                       reject_in,
  output logic                       timeout_in,
  output logic                       timeout_out,
  output logic                       fault
);

  logic reject_entry;
  logic reject_exit;
  logic entered_q;
  logic exited_q;

  parking_gate_fsm #(
    .CHECK_SPACE (1'b1),
    .OPEN_TIMEOUT(OPEN_TIMEOUT),
    .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_entry (
    .clk       (clk),
    .reset     (reset),
    .loop      (in_loop),
    .card_valid(in_card_valid),
    .card_uni  (in_card_uni),
    .pass      (in_pass),
    .uni_space (counter.uni_is_vacated_space),
    .reg_space (counter.is_vacated_space),
    .barrier   (barrier_in_open),
    .car_event (counter.car_entered),
    .car_uni   (counter.is_uni_car_entered),
    .timeout   (timeout_in),
    .reject    (reject_entry)
  );

  parking_gate_fsm #(
    .CHECK_SPACE (1'b0),
    .OPEN_TIMEOUT(OPEN_TIMEOUT),
    .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_exit (
    .clk       (clk),
    .reset     (reset),
    .loop      (out_loop),
    .card_valid(out_card_valid),
    .card_uni  (out_card_uni),
    .pass      (out_pass),
    .uni_space (1'b0),
    .reg_space (1'b0),
    .barrier   (barrier_out_open),
    .car_event (counter.car_exited),
    .car_uni   (counter.is_uni_car_exited),
    .timeout   (timeout_out),
    .reject    (reject_exit)
  );

  // The exit gate never rejects, so its term is constant 0; both instances stay identical.
  assign reject_in = reject_entry | reject_exit;

  // Sticky fault: counter flags an event illegal in the cycle following that event.
  always_ff @(posedge clk) begin
    if (reset) begin
      entered_q <= 1'b0;
      exited_q  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      entered_q <= counter.car_entered;
      exited_q  <= counter.car_exited;
      if ((entered_q && counter.illegal_enter) || (exited_q && counter.illegal_exit))
        fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for the parking gate controller.
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic in_loop, in_card_valid, in_card_uni, in_pass;
  logic out_loop, out_card_valid, out_card_uni, out_pass;
  logic barrier_in_open, barrier_out_open, reject_in, timeout_in, timeout_out, fault;
  logic [9:0] outs;
  int total = 0;
  int bad = 0;

  localparam logic [9:0] B_IN  = 10'b10_0000_0000;
  localparam logic [9:0] B_OUT = 10'b01_0000_0000;
  localparam logic [9:0] REJ   = 10'b00_1000_0000;
  localparam logic [9:0] TO_IN = 10'b00_0100_0000;
  localparam logic [9:0] FLT   = 10'b00_0001_0000;
  localparam logic [9:0] CE    = 10'b00_0000_1000;
  localparam logic [9:0] CEU   = 10'b00_0000_0100;
  localparam logic [9:0] CX    = 10'b00_0000_0010;
  localparam logic [9:0] CXU   = 10'b00_0000_0001;
  localparam logic [9:0] NONE  = 10'b00_0000_0000;

  parking_gate_ctrl_if cif ();

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .in_loop         (in_loop),
    .in_card_valid   (in_card_valid),
    .in_card_uni     (in_card_uni),
    .in_pass         (in_pass),
    .out_loop        (out_loop),
    .out_card_valid  (out_card_valid),
    .out_card_uni    (out_card_uni),
    .out_pass        (out_pass),
    .counter         (cif),
    .barrier_in_open (barrier_in_open),
    .barrier_out_open(barrier_out_open),
    .reject_in       (reject_in),
    .timeout_in      (timeout_in),
    .timeout_out     (timeout_out),
    .fault           (fault)
  );

  assign outs = {barrier_in_open, barrier_out_open, reject_in, timeout_in, timeout_out, fault,
                 cif.car_entered, cif.is_uni_car_entered, cif.car_exited, cif.is_uni_car_exited};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reset for two cycles with all inputs idle; returns at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_loop = 0; in_card_valid = 0; in_card_uni = 0; in_pass = 0;
    out_loop = 0; out_card_valid = 0; out_card_uni = 0; out_pass = 0;
    cif.uni_is_vacated_space = 0; cif.is_vacated_space = 0;
    cif.illegal_enter = 0; cif.illegal_exit = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (outs !== NONE) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, NONE); end
    @(negedge clk);
    total++; if (outs !== NONE) begin bad++; $display("FAIL reset_idle: got %b want %b", outs, NONE); end
  endtask

  task automatic test_regular_entry();
    do_reset();
    cif.is_vacated_space = 1; cif.uni_is_vacated_space = 0;
    in_loop = 1; in_card_valid = 1; in_card_uni = 0;
    @(negedge clk); in_card_valid = 0;
    total++; if (outs !== NONE) begin bad++; $display("FAIL reg_decide: got %b want %b", outs, NONE); end
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL reg_open: got %b want %b", outs, B_IN); end
    in_pass = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (outs !== B_IN) begin bad++; $display("FAIL reg_passing%0d: got %b want %b", i, outs, B_IN); end
    end
    in_pass = 0; in_loop = 0;
    @(negedge clk);
    total++; if (outs !== CE) begin bad++; $display("FAIL reg_event: got %b want %b", outs, CE); end
    // Card held through CLOSE must be ignored until the close hold-off ends.
    in_loop = 1; in_card_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (outs !== NONE) begin bad++; $display("FAIL reg_close%0d: got %b want %b", i, outs, NONE); end
    end
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL reg_close_len: got %b want %b", outs, B_IN); end
  endtask

  task automatic test_uni_overflow();
    do_reset();
    cif.is_vacated_space = 1; cif.uni_is_vacated_space = 0;
    in_loop = 1; in_card_valid = 1; in_card_uni = 1;
    @(negedge clk); in_card_valid = 0;
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL uni_open: got %b want %b", outs, B_IN); end
    in_pass = 1;
    @(negedge clk); in_pass = 0;
    @(negedge clk);
    total++; if (outs !== (CE | CEU)) begin bad++; $display("FAIL uni_event: got %b want %b", outs, CE | CEU); end
    // No space at all: rejected until the loop clears.
    do_reset();
    in_loop = 1; in_card_valid = 1; in_card_uni = 1;
    @(negedge clk); in_card_valid = 0;
    @(negedge clk);
    cif.is_vacated_space = 1;
    total++; if (outs !== REJ) begin bad++; $display("FAIL rej_uni: got %b want %b", outs, REJ); end
    @(negedge clk);
    total++; if (outs !== REJ) begin bad++; $display("FAIL rej_hold: got %b want %b", outs, REJ); end
    in_loop = 0;
    @(negedge clk);
    total++; if (outs !== NONE) begin bad++; $display("FAIL rej_release: got %b want %b", outs, NONE); end
    // Regular card cannot use a university space.
    do_reset();
    cif.uni_is_vacated_space = 1;
    in_loop = 1; in_card_valid = 1; in_card_uni = 0;
    @(negedge clk); in_card_valid = 0;
    @(negedge clk);
    total++; if (outs !== REJ) begin bad++; $display("FAIL rej_regular: got %b want %b", outs, REJ); end
  endtask

  task automatic test_timeout();
    do_reset();
    cif.is_vacated_space = 1;
    in_loop = 1; in_card_valid = 1;
    @(negedge clk); in_card_valid = 0;
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL to_open: got %b want %b", outs, B_IN); end
    repeat (63) @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL to_last_open: got %b want %b", outs, B_IN); end
    @(negedge clk);
    total++; if (outs !== TO_IN) begin bad++; $display("FAIL to_pulse: got %b want %b", outs, TO_IN); end
    @(negedge clk);
    total++; if (outs !== NONE) begin bad++; $display("FAIL to_after: got %b want %b", outs, NONE); end
    // Pass rising on the expiry cycle wins over the timeout.
    do_reset();
    cif.is_vacated_space = 1;
    in_loop = 1; in_card_valid = 1;
    @(negedge clk); in_card_valid = 0;
    repeat (64) @(negedge clk);
    in_pass = 1;
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL to_race: got %b want %b", outs, B_IN); end
    in_pass = 0;
    @(negedge clk);
    total++; if (outs !== CE) begin bad++; $display("FAIL to_race_event: got %b want %b", outs, CE); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cif.is_vacated_space = 1; cif.uni_is_vacated_space = 1;
    in_loop = 1; in_card_valid = 1; in_card_uni = 1;
    out_loop = 1; out_card_valid = 1; out_card_uni = 0;
    @(negedge clk); in_card_valid = 0; out_card_valid = 0;
    @(negedge clk);
    total++; if (outs !== (B_IN | B_OUT)) begin bad++; $display("FAIL sim_open: got %b want %b", outs, B_IN | B_OUT); end
    in_pass = 1; out_pass = 1;
    @(negedge clk); in_pass = 0; out_pass = 0;
    @(negedge clk);
    total++; if (outs !== (CE | CEU | CX)) begin bad++; $display("FAIL sim_events: got %b want %b", outs, CE | CEU | CX); end
  endtask

  task automatic test_fault();
    do_reset();
    cif.illegal_enter = 1; cif.illegal_exit = 1;
    repeat (3) @(negedge clk);
    total++; if (outs !== NONE) begin bad++; $display("FAIL fault_stray: got %b want %b", outs, NONE); end
    cif.illegal_enter = 0; cif.illegal_exit = 0;
    out_loop = 1; out_card_valid = 1; out_card_uni = 1;
    @(negedge clk); out_card_valid = 0;
    @(negedge clk);
    out_pass = 1;
    @(negedge clk); out_pass = 0;
    @(negedge clk);
    total++; if (outs !== (CX | CXU)) begin bad++; $display("FAIL fault_exit_event: got %b want %b", outs, CX | CXU); end
    @(negedge clk);
    cif.illegal_exit = 1; cif.illegal_enter = 1;
    total++; if (outs !== NONE) begin bad++; $display("FAIL fault_not_yet: got %b want %b", outs, NONE); end
    @(negedge clk);
    cif.illegal_exit = 0; cif.illegal_enter = 0;
    total++; if (outs !== FLT) begin bad++; $display("FAIL fault_set: got %b want %b", outs, FLT); end
    repeat (5) @(negedge clk);
    total++; if (outs !== FLT) begin bad++; $display("FAIL fault_sticky: got %b want %b", outs, FLT); end
    do_reset();
    total++; if (outs !== NONE) begin bad++; $display("FAIL fault_reset: got %b want %b", outs, NONE); end
  endtask

  task automatic test_reset_mid_passing();
    do_reset();
    cif.is_vacated_space = 1;
    in_loop = 1; in_card_valid = 1;
    @(negedge clk); in_card_valid = 0;
    @(negedge clk);
    in_pass = 1;
    @(negedge clk);
    total++; if (outs !== B_IN) begin bad++; $display("FAIL rst_passing: got %b want %b", outs, B_IN); end
    reset = 1;
    @(negedge clk);
    total++; if (outs !== NONE) begin bad++; $display("FAIL rst_cleared: got %b want %b", outs, NONE); end
    reset = 0;
    @(negedge clk); in_pass = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (outs !== NONE) begin bad++; $display("FAIL rst_no_event%0d: got %b want %b", i, outs, NONE); end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_regular_entry();
    test_uni_overflow();
    test_timeout();
    test_simultaneous();
    test_fault();
    test_reset_mid_passing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
